// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register: state
// encoding (numerically equal to occupancy) and a channel-slice helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    localparam int CHAN_MAX_W = 64;
    localparam int BUS_MAX_W  = 1024;

    // Extract channel k of width w from a flattened bus (zero-extended to BUS_MAX_W).
    function automatic logic [CHAN_MAX_W-1:0] chan(input logic [BUS_MAX_W-1:0] bus,
                                                   input int unsigned k,
                                                   input int unsigned w);
        logic [BUS_MAX_W-1:0]  shifted;
        logic [CHAN_MAX_W-1:0] mask;
        shifted = bus >> (k * w);
        mask    = (w >= CHAN_MAX_W) ? '1 : ((CHAN_MAX_W'(1) << w) - CHAN_MAX_W'(1));
        return shifted[CHAN_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage entry of the pipeline stage: a NUM_CH*DATA_W wide register
// with load enable, cleared by asynchronous reset.
module pipe_entry #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [NUM_CH*DATA_W-1:0] d,
    output logic [NUM_CH*DATA_W-1:0] q
);

    // Hold the bundle; capture d only when load is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, synchronous
// flush and optional skid entry.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_EMPTY | no bundle held, out_valid=0
//   ST_ONE   | main entry live, drives out_data
//   ST_TWO   | main and skid live (SKID=1 only), in_ready=0
//
// The state encoding equals the occupancy, so occ is the state register.
// Flush only moves the state to ST_EMPTY; data flops keep their contents.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 3,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [1:0]               occ,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int BUS_W = NUM_CH * DATA_W;

    pipe_state_t      state, state_nxt;
    logic             push, pop;
    logic             main_load, skid_load;
    logic [BUS_W-1:0] main_d, skid_q;

    assign out_valid = (state != ST_EMPTY);
    assign occ       = state;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // With a skid entry, ready comes straight from the state flop; without
    // one, a full stage can only accept when the head leaves this cycle.
    if (SKID != 0) begin : g_rdy_skid
        assign in_ready = (state != ST_TWO);
    end else begin : g_rdy_noskid
        assign in_ready = (state == ST_EMPTY) || out_ready;
    end

    // Next-state and entry-load decode; flush overrides every transfer.
    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_data;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        state_nxt = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (pop) begin
                        state_nxt = ST_EMPTY;
                    end else if (push && (SKID != 0)) begin
                        state_nxt = ST_TWO;
                        skid_load = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_nxt = ST_ONE;
                        main_load = 1'b1;
                        main_d    = skid_q;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_EMPTY;
        else
            state <= state_nxt;
    end

    // Saturating count of cycles where the head is blocked downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    pipe_entry #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (out_data)
    );

    if (SKID != 0) begin : g_skid
        pipe_entry #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) u_skid (
            .clk  (clk),
            .rst  (rst),
            .load (skid_load),
            .d    (in_data),
            .q    (skid_q)
        );
    end else begin : g_no_skid
        logic skid_unused;
        assign skid_unused = skid_load;
        assign skid_q      = '0;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 (16-bit and 4-bit stall
// counters, shared stimulus) and SKID=0 instances.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [95:0] in_data = '0;
    logic        v0 = 1'b0;
    logic        r0 = 1'b0;
    logic [95:0] d0 = '0;

    logic        rdy1, val1, rdy4, val4, rdy0, val0;
    logic [95:0] dat1, dat4, dat0;
    logic [1:0]  occ1, occ4, occ0;
    logic [15:0] st1, st0;
    logic [3:0]  st4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .NUM_CH(3), .SKID(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .out_valid(val1), .out_ready(out_ready), .out_data(dat1),
        .occ(occ1), .stall_cnt(st1));

    pipe_stage_reg #(.DATA_W(32), .NUM_CH(3), .SKID(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
        .in_data(in_data), .out_valid(val4), .out_ready(out_ready), .out_data(dat4),
        .occ(occ4), .stall_cnt(st4));

    pipe_stage_reg #(.DATA_W(32), .NUM_CH(3), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(v0), .in_ready(rdy0),
        .in_data(d0), .out_valid(val0), .out_ready(r0), .out_data(dat0),
        .occ(occ0), .stall_cnt(st0));

    function automatic logic [95:0] mk(input int i);
        return {32'(32'h30 + i), 32'(32'h20 + i), 32'(32'h10 + i)};
    endfunction

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values, checked asynchronously before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk_n("rst_val", int'(val1), 0);
        chk_n("rst_occ", int'(occ1), 0);
        chk_d("rst_dat", dat1, '0);
        chk_n("rst_stall", int'(st1), 0);
        chk_n("rst_rdy1", int'(rdy1), 1);
        chk_n("rst_rdy0", int'(rdy0), 1);
        #6 rst = 1'b0;
        tick();

        // Streaming with out_ready=1: one bundle per cycle, one-cycle latency.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = mk(i);
            tick();
            chk_n("strm_val", int'(val1), 1);
            chk_d("strm_dat", dat1, mk(i));
            chk_n("strm_occ", int'(occ1), 1);
            chk_n("strm_rdy", int'(rdy1), 1);
        end
        chk_n("strm_ch2", int'(chan(BUS_MAX_W'(dat1), 2, 32)), 32'h35);
        chk_n("strm_stall", int'(st1), 0);

        // Backpressure: one bundle lands in the skid, then ready drops.
        out_ready = 1'b0;
        in_data   = mk(6);
        tick();
        chk_n("bp_occ2", int'(occ1), 2);
        chk_n("bp_rdy0", int'(rdy1), 0);
        chk_d("bp_head", dat1, mk(5));
        in_data = mk(7);
        tick();
        tick();
        chk_n("bp_stall3", int'(st1), 3);
        chk_n("bp_occ", int'(occ1), 2);
        chk_d("bp_head2", dat1, mk(5));
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        chk_d("drain_1", dat1, mk(6));
        chk_n("drain_occ", int'(occ1), 1);
        chk_n("drain_rdy", int'(rdy1), 1);
        tick();
        chk_n("drain_val", int'(val1), 0);
        chk_n("drain_stall", int'(st1), 3);
        chk_n("drain_stall4", int'(st4), 3);

        // Flush from occ=2 with concurrent push.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mk(8);
        tick();
        in_data = mk(9);
        tick();
        chk_n("fl_pre_occ", int'(occ1), 2);
        chk_n("fl_pre_stall", int'(st1), 4);
        flush     = 1'b1;
        in_data   = mk(10);
        out_ready = 1'b1;
        tick();
        flush   = 1'b0;
        in_data = mk(11);
        chk_n("fl_occ", int'(occ1), 0);
        chk_n("fl_val", int'(val1), 0);
        chk_n("fl_stall", int'(st1), 4);
        chk_n("fl_rdy", int'(rdy1), 1);
        tick();
        chk_d("fl_next", dat1, mk(11));
        chk_n("fl_next_occ", int'(occ1), 1);
        // Flush while in_ready=1: the push is dropped.
        flush   = 1'b1;
        in_data = mk(12);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_n("fl2_occ", int'(occ1), 0);
        chk_n("fl2_val", int'(val1), 0);
        tick();
        chk_n("fl2_gone", int'(occ1), 0);

        // Stall counter saturation on the 4-bit instance.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mk(13);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk_n("sat_14", int'(st4), 14);
        tick();
        chk_n("sat_15", int'(st4), 15);
        repeat (9) tick();
        chk_n("sat_hold", int'(st4), 15);
        chk_n("sat_wide", int'(st1), 24);
        chk_d("sat_head", dat1, mk(13));

        // Asynchronous reset between edges with occ=2.
        in_valid = 1'b1;
        in_data  = mk(14);
        tick();
        in_valid = 1'b0;
        chk_n("ar_pre_occ", int'(occ1), 2);
        #2 rst = 1'b1;
        #1;
        chk_n("ar_val", int'(val1), 0);
        chk_n("ar_occ", int'(occ1), 0);
        chk_d("ar_dat", dat1, '0);
        chk_n("ar_stall", int'(st1), 0);
        rst = 1'b0;
        tick();
        in_valid  = 1'b1;
        in_data   = mk(15);
        out_ready = 1'b1;
        tick();
        chk_n("ar_post_val", int'(val1), 1);
        chk_d("ar_post_dat", dat1, mk(15));
        in_valid = 1'b0;
        tick();

        // SKID=0: combinational in_ready.
        v0 = 1'b1;
        d0 = mk(20);
        r0 = 1'b0;
        #1;
        chk_n("s0_rdy_empty", int'(rdy0), 1);
        tick();
        d0 = mk(21);
        #1;
        chk_n("s0_rdy_full", int'(rdy0), 0);
        chk_n("s0_occ", int'(occ0), 1);
        chk_d("s0_dat", dat0, mk(20));
        tick();
        chk_d("s0_hold", dat0, mk(20));
        chk_n("s0_stall", int'(st0), 1);
        r0 = 1'b1;
        #1;
        chk_n("s0_rdy_pass", int'(rdy0), 1);
        tick();
        chk_d("s0_pp", dat0, mk(21));
        chk_n("s0_pp_occ", int'(occ0), 1);
        d0 = mk(22);
        tick();
        chk_d("s0_strm", dat0, mk(22));
        v0 = 1'b0;
        tick();
        chk_n("s0_empty", int'(occ0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
